// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: merges the mem-stall, load-use and branch-flush requests into
// per-stage write enables, flushes and bubbles, plus a mem-stall watchdog and perf counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int WAIT_W    = 8,
    parameter int MAX_STALL = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_stall_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             mem_wb_bubble_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_STALL = 2'd1,
        TIMEOUT   = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_W   = WAIT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_q, flush_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    // Control is combinational so the enables act in the cycle the request arrives.
    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_write_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_write_o  = 1'b0;
        mem_wb_write_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (rst_i && (state_q != TIMEOUT)) begin
            if (mem_stall_i) begin
                mem_wb_write_o  = 1'b1;
                mem_wb_bubble_o = 1'b1;
                // wait_q is always 0 in RUN, so this also performs the load-with-1.
                wait_d  = wait_q + 1'b1;
                state_d = (wait_d >= MAX_W) ? TIMEOUT : MEM_STALL;
            end else begin
                state_d        = RUN;
                wait_d         = '0;
                id_ex_write_o  = 1'b1;
                ex_mem_write_o = 1'b1;
                mem_wb_write_o = 1'b1;
                if (hazard_stall_i) begin
                    id_ex_bubble_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                    if_id_flush_o = branch_taken_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= sat_inc(stall_q, (state_q != TIMEOUT) && !pc_write_o);
            flush_q <= sat_inc(flush_q, if_id_flush_o);
        end
    end

    assign state_o     = state_q;
    assign timeout_o   = (state_q == TIMEOUT);
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: two controllers (default and CNT_W=3/MAX_STALL=4) share random stimulus and
// are compared every cycle against a mode-table reference model.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n, haz, br, mem;
    always #5 clk = ~clk;

    logic        a_pc, a_ifw, a_iff, a_idw, a_idb, a_exw, a_wbw, a_wbb, a_to;
    logic [1:0]  a_st;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_iff, b_idw, b_idb, b_exw, b_wbw, b_wbb, b_to;
    logic [1:0]  b_st;
    logic [2:0]  b_sc, b_fc;

    pipeline_stall_ctrl dut_a (
        .clk_i(clk), .rst_i(rst_n), .hazard_stall_i(haz), .branch_taken_i(br), .mem_stall_i(mem),
        .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_iff), .id_ex_write_o(a_idw),
        .id_ex_bubble_o(a_idb), .ex_mem_write_o(a_exw), .mem_wb_write_o(a_wbw),
        .mem_wb_bubble_o(a_wbb), .state_o(a_st), .timeout_o(a_to), .stall_cnt_o(a_sc),
        .flush_cnt_o(a_fc)
    );

    pipeline_stall_ctrl #(.CNT_W(3), .WAIT_W(8), .MAX_STALL(4)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .hazard_stall_i(haz), .branch_taken_i(br), .mem_stall_i(mem),
        .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_iff), .id_ex_write_o(b_idw),
        .id_ex_bubble_o(b_idb), .ex_mem_write_o(b_exw), .mem_wb_write_o(b_wbw),
        .mem_wb_bubble_o(b_wbb), .state_o(b_st), .timeout_o(b_to), .stall_cnt_o(b_sc),
        .flush_cnt_o(b_fc)
    );

    typedef struct packed {
        logic [7:0]  a_ctrl;
        logic [2:0]  a_tost;
        logic [15:0] a_stall;
        logic [15:0] a_flush;
        logic [7:0]  b_ctrl;
        logic [2:0]  b_tost;
        logic [2:0]  b_stall;
        logic [2:0]  b_flush;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: per-instance watchdog/counter bookkeeping in plain integers.
    int maxs[2] = '{255, 4};
    int caps[2] = '{65535, 7};
    int m_to[2], m_run[2], m_stall[2], m_flush[2];

    // Stage enables listed as {pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, mem_wb_w, mem_wb_bubble}.
    function automatic logic [7:0] ctrl_of(input logic r, input logic t, input logic h,
                                           input logic b, input logic m);
        if (!r || t) return 8'b0000_0000;
        if (m)       return 8'b0000_0011;
        if (h)       return 8'b0001_1110;
        if (b)       return 8'b1111_0110;
        return 8'b1101_0110;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic h, input logic b, input logic m);
        exp_t e;
        @(negedge clk);
        rst_n = r; haz = h; br = b; mem = m;
        e.a_ctrl  = ctrl_of(r, m_to[0] != 0, h, b, m);
        e.a_tost  = {m_to[0] != 0, m_to[0] != 0 ? 2'd2 : (m_run[0] > 0 ? 2'd1 : 2'd0)};
        e.a_stall = 16'(m_stall[0]);
        e.a_flush = 16'(m_flush[0]);
        e.b_ctrl  = ctrl_of(r, m_to[1] != 0, h, b, m);
        e.b_tost  = {m_to[1] != 0, m_to[1] != 0 ? 2'd2 : (m_run[1] > 0 ? 2'd1 : 2'd0)};
        e.b_stall = 3'(m_stall[1]);
        e.b_flush = 3'(m_flush[1]);
        exp_q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                m_to[i] = 0; m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else if (m_to[i] == 0) begin
                if (m) begin
                    m_run[i]++;
                    if (m_run[i] >= maxs[i]) m_to[i] = 1;
                    if (m_stall[i] < caps[i]) m_stall[i]++;
                end else begin
                    m_run[i] = 0;
                    if (h) begin
                        if (m_stall[i] < caps[i]) m_stall[i]++;
                    end else if (b) begin
                        if (m_flush[i] < caps[i]) m_flush[i]++;
                    end
                end
            end
        end
    endtask

    task automatic repeat_apply(input int n, input logic r, input logic h, input logic b, input logic m);
        for (int k = 0; k < n; k++) apply(r, h, b, m);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_ctrl",  32'({a_pc, a_ifw, a_iff, a_idw, a_idb, a_exw, a_wbw, a_wbb}), 32'(e.a_ctrl));
                check("a_state", 32'({a_to, a_st}), 32'(e.a_tost));
                check("a_stall", 32'(a_sc), 32'(e.a_stall));
                check("a_flush", 32'(a_fc), 32'(e.a_flush));
                check("b_ctrl",  32'({b_pc, b_ifw, b_iff, b_idw, b_idb, b_exw, b_wbw, b_wbb}), 32'(e.b_ctrl));
                check("b_state", 32'({b_to, b_st}), 32'(e.b_tost));
                check("b_stall", 32'(b_sc), 32'(e.b_stall));
                check("b_flush", 32'(b_fc), 32'(e.b_flush));
            end
        end
    end

    initial begin : stimulus
        int mem_left;
        logic r, h, b, m;
        rst_n = 1'b0; haz = 1'b0; br = 1'b0; mem = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_to[i] = 0; m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        repeat (2) @(posedge clk);
        repeat_apply(2, 0, 0, 0, 0);
        repeat_apply(3, 1, 0, 0, 0);
        apply(1, 1, 0, 0); apply(1, 0, 0, 0);
        apply(1, 1, 1, 0); apply(1, 0, 1, 0); apply(1, 0, 0, 0);
        repeat_apply(10, 1, 0, 1, 1); apply(1, 0, 1, 0); repeat_apply(2, 1, 0, 0, 0);
        repeat_apply(8, 1, 0, 0, 1); repeat_apply(2, 1, 1, 1, 0);
        apply(0, 0, 0, 0); repeat_apply(2, 1, 0, 0, 0);
        repeat_apply(9, 1, 1, 0, 0);
        repeat_apply(3, 1, 0, 0, 1); apply(0, 0, 0, 1); apply(1, 0, 0, 0);
        repeat_apply(2, 1, 0, 0, 1); apply(1, 1, 0, 0); apply(1, 0, 1, 0);
        mem_left = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 3) == 0);
            if (mem_left == 0 && $urandom_range(0, 14) == 0) mem_left = $urandom_range(1, 8);
            m = (mem_left > 0);
            if (mem_left > 0) mem_left--;
            apply(r, h, b, m);
        end
        apply(0, 0, 0, 0);
        repeat_apply(260, 1, 1, 1, 1);
        repeat_apply(2, 1, 1, 1, 0);
        apply(0, 1, 1, 1); repeat_apply(2, 1, 0, 1, 0);
        @(negedge clk);
        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
